// File: rtl/gf180mcu_osu_sc_9t_lsdom_seq.sv
// Power sequencer for a low-voltage island behind lshifup level shifters:
// orders switch, shifter enable and clamps, REQ/ACK handshake, sticky fault.
module gf180mcu_osu_sc_9t_lsdom_seq #(
   parameter int CNT_W  = 8,
   parameter int T_RAMP = 16,
   parameter int T_ISO  = 4,
   parameter int T_TO   = 200
) (
   input  logic       CLK,
   input  logic       RN,
   input  logic       REQ,
   input  logic       PGOOD,
   output logic       ACK,
   output logic       PSW_EN,
   output logic       LS_EN,
   output logic       ISO_N,
   output logic       ERR,
   output logic [2:0] STATE
);

   localparam logic [2:0] S_OFF   = 3'd0;
   localparam logic [2:0] S_RAMP  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_UNISO = 3'd3;
   localparam logic [2:0] S_ON    = 3'd4;
   localparam logic [2:0] S_ISO   = 3'd5;
   localparam logic [2:0] S_DRAIN = 3'd6;
   localparam logic [2:0] S_FAULT = 3'd7;

   localparam logic [CNT_W-1:0] C_RAMP = CNT_W'(T_RAMP - 1);
   localparam logic [CNT_W-1:0] C_ISO  = CNT_W'(T_ISO - 1);
   localparam logic [CNT_W-1:0] C_TO   = CNT_W'(T_TO - 1);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pg_meta;
   logic             r_pg_s;

   logic [2:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_dec;
   logic             w_cnt_zero;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_cnt_dec  = w_cnt_zero ? '0 : r_cnt - CNT_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_cnt_dec;
      case (r_state)
         S_OFF:
            if (REQ) begin w_state_nxt = S_RAMP; w_cnt_nxt = C_RAMP; end
         S_RAMP:
            if (!REQ)           begin w_state_nxt = S_DRAIN; w_cnt_nxt = C_RAMP; end
            else if (w_cnt_zero) begin w_state_nxt = S_WAIT;  w_cnt_nxt = C_TO;   end
         S_WAIT:
            // Withdrawn request wins over power-good and timeout.
            if (!REQ)            begin w_state_nxt = S_DRAIN; w_cnt_nxt = C_RAMP; end
            else if (r_pg_s)     begin w_state_nxt = S_UNISO; w_cnt_nxt = C_ISO;  end
            else if (w_cnt_zero) w_state_nxt = S_FAULT;
         S_UNISO:
            if (!r_pg_s)         w_state_nxt = S_FAULT;
            else if (!REQ)       begin w_state_nxt = S_ISO; w_cnt_nxt = C_ISO; end
            else if (w_cnt_zero) w_state_nxt = S_ON;
         S_ON:
            if (!r_pg_s)         w_state_nxt = S_FAULT;
            else if (!REQ)       begin w_state_nxt = S_ISO; w_cnt_nxt = C_ISO; end
         S_ISO:
            if (w_cnt_zero) begin w_state_nxt = S_DRAIN; w_cnt_nxt = C_RAMP; end
         S_DRAIN:
            if (w_cnt_zero) w_state_nxt = S_OFF;
         default:
            if (!REQ) w_state_nxt = S_OFF;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RN) begin
         r_state   <= S_OFF;
         r_cnt     <= '0;
         r_pg_meta <= 1'b0;
         r_pg_s    <= 1'b0;
      end else begin
         r_pg_meta <= PGOOD;
         r_pg_s    <= r_pg_meta;
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   // Pure decode of the state flop, so ISO_N can never lead LS_EN/PSW_EN.
   always_comb begin
      PSW_EN = 1'b0;
      LS_EN  = 1'b0;
      ISO_N  = 1'b0;
      ACK    = 1'b0;
      ERR    = 1'b0;
      case (r_state)
         S_RAMP, S_WAIT: PSW_EN = 1'b1;
         S_UNISO: begin PSW_EN = 1'b1; LS_EN = 1'b1; end
         S_ON:    begin PSW_EN = 1'b1; LS_EN = 1'b1; ISO_N = 1'b1; ACK = 1'b1; end
         S_ISO:   begin PSW_EN = 1'b1; LS_EN = 1'b1; ACK = 1'b1; end
         S_DRAIN: ACK = 1'b1;
         S_FAULT: ERR = 1'b1;
         default: ;
      endcase
   end

   assign STATE = r_state;

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_lsdom_seq.sv
// Scoreboard bench: expected state/output vectors are queued per driven edge
// and popped after that edge, using T_RAMP=4, T_ISO=2, T_TO=8.
module tb_gf180mcu_osu_sc_9t_lsdom_seq;

   logic       CLK = 1'b0;
   logic       RN = 1'b0, REQ = 1'b0, PGOOD = 1'b0;
   logic       ACK, PSW_EN, LS_EN, ISO_N, ERR;
   logic [2:0] STATE;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   gf180mcu_osu_sc_9t_lsdom_seq #(.CNT_W(8), .T_RAMP(4), .T_ISO(2), .T_TO(8)) dut (
      .CLK(CLK), .RN(RN), .REQ(REQ), .PGOOD(PGOOD),
      .ACK(ACK), .PSW_EN(PSW_EN), .LS_EN(LS_EN), .ISO_N(ISO_N),
      .ERR(ERR), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   // {STATE, PSW_EN, LS_EN, ISO_N, ACK, ERR} from the state table
   function automatic logic [7:0] exp_vec(input int s);
      logic [4:0] o;
      case (s)
         0: o = 5'b00000;
         1: o = 5'b10000;
         2: o = 5'b10000;
         3: o = 5'b11000;
         4: o = 5'b11110;
         5: o = 5'b11010;
         6: o = 5'b00010;
         default: o = 5'b00001;
      endcase
      return {3'(s), o};
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got st=%0d out=%b, want st=%0d out=%b",
                  tag, got[7:5], got[4:0], exp[7:5], exp[4:0]);
      end
   endtask

   // Drive one edge's inputs, queue the expected post-edge state, then compare.
   task automatic step(input string tag, input logic rn, input logic req,
                       input logic pg, input int exp_state);
      logic [7:0] e;
      @(negedge CLK);
      RN = rn; REQ = req; PGOOD = pg;
      exp_q.push_back(exp_vec(exp_state));
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      chk(tag, {STATE, PSW_EN, LS_EN, ISO_N, ACK, ERR}, e);
   endtask

   task automatic run(input string tag, input logic rn, input logic req,
                      input logic pg, input int states[]);
      foreach (states[i]) step($sformatf("%s[%0d]", tag, i), rn, req, pg, states[i]);
   endtask

   initial begin
      // reset state
      run("rst", 1'b0, 1'b0, 1'b1, '{0, 0});
      // power-up with PGOOD high
      run("up", 1'b1, 1'b1, 1'b1, '{1, 1, 1, 1, 2, 3, 3, 4, 4});
      // power-down; REQ pulse during ISO must be ignored
      step("dn0", 1'b1, 1'b0, 1'b1, 5);
      step("dn1", 1'b1, 1'b1, 1'b1, 5);
      run("dn", 1'b1, 1'b0, 1'b1, '{6, 6, 6, 6, 0, 0});
      // PGOOD stuck low: timeout into FAULT, held while REQ stays high
      run("to_rst", 1'b0, 1'b0, 1'b0, '{0});
      run("to", 1'b1, 1'b1, 1'b0, '{1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 7, 7, 7});
      step("to_clr", 1'b1, 1'b0, 1'b0, 0);
      // PGOOD loss while ON
      run("pgl_up", 1'b1, 1'b1, 1'b1, '{1, 1, 1, 1, 2, 3, 3, 4});
      run("pgl", 1'b1, 1'b1, 1'b0, '{4, 4, 7});
      run("pgl_hold", 1'b1, 1'b1, 1'b1, '{7, 7, 7, 7});
      step("pgl_clr", 1'b1, 1'b0, 1'b1, 0);
      // REQ withdrawn during RAMP
      run("rabt_up", 1'b1, 1'b1, 1'b1, '{1, 1});
      run("rabt", 1'b1, 1'b0, 1'b1, '{6, 6, 6, 6, 0, 0});
      // reset asserted in UNISO with REQ held, then restart
      run("ru_up", 1'b1, 1'b1, 1'b1, '{1, 1, 1, 1, 2, 3});
      run("ru_rst", 1'b0, 1'b1, 1'b1, '{0, 0});
      run("ru_re", 1'b1, 1'b1, 1'b1, '{1, 1, 1, 1, 2, 3, 3, 4});
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
